// File: rtl/byte_unloader.sv
// Purpose: parallel-in serial-out unloader; captures six bytes on load and streams them oldest first.
// Latency: first byte valid the cycle after load is sampled; one byte per cycle with dout_ready held high.
// Backpressure: dout_ready low holds dout and the index stable for any number of cycles.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   load, flush     capture request (honoured only in IDLE), synchronous abort to IDLE
//   din0..din5      parallel bytes, din5 oldest / first out, din0 newest / last out
//   dout, dout_valid, dout_ready   valid/ready serial byte stream
//   busy, done      not-IDLE indicator, one-cycle end-of-frame pulse
module byte_unloader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             flush,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    input  logic [WIDTH-1:0] din4,
    input  logic [WIDTH-1:0] din5,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;
    logic [WIDTH-1:0] byte_q [0:5];
    logic [WIDTH-1:0] byte_sel;
    logic             capture;

    // Capture only from IDLE; flush outranks load so an aborting cycle never overwrites the buffer.
    assign capture = (state == IDLE) && load && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= 3'd0;
            for (int i = 0; i < 6; i++) begin
                byte_q[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (capture) begin
                byte_q[0] <= din0;
                byte_q[1] <= din1;
                byte_q[2] <= din2;
                byte_q[3] <= din3;
                byte_q[4] <= din4;
                byte_q[5] <= din5;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (flush) begin
            state_nxt = IDLE;
            idx_nxt   = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state_nxt = SEND;
                        idx_nxt   = 3'd5;
                    end
                end
                SEND: begin
                    if (dout_ready) begin
                        if (idx == 3'd0) begin
                            state_nxt = DONE;
                        end else begin
                            idx_nxt = idx - 3'd1;
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = 3'd0;
                end
            endcase
        end
    end

    // Explicit mux keeps the unused index codes 6 and 7 from reading past the buffer.
    always_comb begin
        byte_sel = '0;
        case (idx)
            3'd0:    byte_sel = byte_q[0];
            3'd1:    byte_sel = byte_q[1];
            3'd2:    byte_sel = byte_q[2];
            3'd3:    byte_sel = byte_q[3];
            3'd4:    byte_sel = byte_q[4];
            3'd5:    byte_sel = byte_q[5];
            default: byte_sel = '0;
        endcase
    end

    // All outputs decode the registered state, so reset forces them low immediately.
    assign dout_valid = (state == SEND);
    assign dout       = dout_valid ? byte_sel : '0;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_byte_unloader.sv
// Purpose: randomized and directed scoreboard bench for byte_unloader.
// Latency: model predicts every cycle's outputs from the frame queue of expected bytes.
// Backpressure: dout_ready is driven directly, including long and alternating stalls.
module tb_byte_unloader;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             load;
    logic             flush;
    logic [WIDTH-1:0] din0, din1, din2, din3, din4, din5;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             done;

    byte_unloader #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .flush      (flush),
        .din0       (din0),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .din4       (din4),
        .din5       (din5),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int vld_cnt  = 0;
    int rise_q[$];

    // Scoreboard: bytes still owed by the current frame, oldest first.
    logic [WIDTH-1:0] exp_q[$];
    logic             m_done  = 1'b0;
    logic             prev_vld = 1'b0;
    logic             m_vld;
    logic [WIDTH-1:0] m_dout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor and reference model, sampled mid-cycle while inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_dout", {24'd0, dout}, 32'd0);
            chk("rst_valid", {31'd0, dout_valid}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            exp_q.delete();
            m_done   = 1'b0;
            prev_vld = 1'b0;
        end else begin
            m_vld  = (exp_q.size() > 0);
            m_dout = m_vld ? exp_q[0] : '0;
            chk("valid", {31'd0, dout_valid}, {31'd0, m_vld});
            chk("busy", {31'd0, busy}, {31'd0, (m_vld || m_done)});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("dout", {24'd0, dout}, {24'd0, m_dout});
            if (m_vld) vld_cnt++;
            if (m_vld && !prev_vld) rise_q.push_back(cyc);
            prev_vld = m_vld;
            // What the coming edge does to the frame.
            if (flush) begin
                exp_q.delete();
                m_done = 1'b0;
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (m_vld) begin
                if (dout_ready) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) m_done = 1'b1;
                end
            end else if (load) begin
                exp_q.push_back(din5);
                exp_q.push_back(din4);
                exp_q.push_back(din3);
                exp_q.push_back(din2);
                exp_q.push_back(din1);
                exp_q.push_back(din0);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_din(input logic [WIDTH-1:0] b5, b4, b3, b2, b1, b0);
        din5 = b5; din4 = b4; din3 = b3; din2 = b2; din1 = b1; din0 = b0;
    endtask

    task automatic pulse_load;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; flush = 1'b0; dout_ready = 1'b0;
        set_din(8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
        step(3);
        rst = 1'b1;
        step(2);

        // Basic frame at full throughput.
        set_din(8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00);
        dout_ready = 1'b1;
        pulse_load();
        step(9);

        // Alternating ready: six bytes need eleven SEND cycles.
        dout_ready = 1'b0;
        vld_cnt = 0;
        pulse_load();
        for (int i = 0; i < 14; i++) begin
            dout_ready = (i % 2 == 0);
            step(1);
        end
        chk("toggle_send_cycles", vld_cnt, 32'd11);
        dout_ready = 1'b1;
        step(2);

        // Load attempts during SEND are ignored and must not disturb the buffer.
        set_din(8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10);
        pulse_load();
        set_din(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        step(1);
        load = 1'b1;
        step(3);
        load = 1'b0;
        step(6);

        // Flush after the third transfer, then a fresh frame.
        set_din(8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'h20);
        pulse_load();
        step(2);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(2);
        set_din(8'h35, 8'h34, 8'h33, 8'h32, 8'h31, 8'h30);
        pulse_load();
        step(8);

        // Flush coinciding with the last transfer suppresses done.
        set_din(8'h45, 8'h44, 8'h43, 8'h42, 8'h41, 8'h40);
        pulse_load();
        step(5);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(3);

        // Asynchronous reset between edges in mid-frame.
        set_din(8'h65, 8'h64, 8'h63, 8'h62, 8'h61, 8'h60);
        pulse_load();
        step(1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_dout", {24'd0, dout}, 32'd0);
        chk("async_valid", {31'd0, dout_valid}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_done", {31'd0, done}, 32'd0);
        step(2);
        rst = 1'b1;
        set_din(8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0);
        pulse_load();
        chk("post_rst_first", {24'd0, dout}, 32'hA5);
        step(8);

        // Load held high: frames start every eight cycles.
        rise_q.delete();
        set_din(8'h75, 8'h74, 8'h73, 8'h72, 8'h71, 8'h70);
        load = 1'b1;
        step(20);
        load = 1'b0;
        step(8);
        if (rise_q.size() < 3) begin
            chk("b2b_frames", rise_q.size(), 32'd3);
        end else begin
            chk("b2b_period1", rise_q[1] - rise_q[0], 32'd8);
            chk("b2b_period2", rise_q[2] - rise_q[1], 32'd8);
        end

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            load       = ($urandom_range(0, 9) < 3);
            flush      = ($urandom_range(0, 49) == 0);
            dout_ready = ($urandom_range(0, 9) < 6);
            set_din(8'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), 8'($urandom), 8'($urandom));
            step(1);
        end
        load = 1'b0; flush = 1'b0; dout_ready = 1'b1;
        step(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
